clint_mc: RTL
=============

// Module: clint_mc
// PURPOSE
//  Multi-core RISC-V core-local interruptor. Holds a 64-bit mtime counter advanced by a real-time clock,
//  one 64-bit mtimecmp and one msip bit per core, and drives per-core mtip/msip. Slave on the native
//  valid/ready peripheral bus; sits beside the CPU cluster in the SoC interrupt path.
// PARAMETERS
//  ADDR_W   16  byte-address width (map needs 16 bits)
//  DATA_W   32  bus data width (only 32 supported)
//  N_CORES  1   cores, 1..32: count of mtimecmp/msip registers and interrupt lines
// PORTS
//  clk      in   1         system clock
//  reset    in   1         asynchronous, active-high reset
//  valid    in   1         request valid; held high until ready
//  address  in   ADDR_W    byte address; bits [1:0] ignored
//  wdata    in   DATA_W    write data
//  wstrb    in   DATA_W/8  byte strobes; 0 = read, nonzero = write
//  rdata    out  DATA_W    read data, valid when ready=1
//  ready    out  1         one-cycle acknowledge
//  rt_clk   in   1         asynchronous real-time clock (typ. 32.768 kHz)
//  mtip     out  N_CORES   machine timer interrupt per core
//  msip     out  N_CORES   machine software interrupt per core
// BEHAVIOUR
//  Reset (async, immediate): mtime=0, mtimecmp[i]=64'hFFFF_FFFF_FFFF_FFFF, msip reg=0, mtip=0, msip=0, ready=0, rdata=0.
//  Address map (byte offsets):
//   0x0000+4*i   msip[i]: bit0 RW, bits[31:1] read 0
//   0x4000+8*i   mtimecmp[i][31:0];   0x4004+8*i  mtimecmp[i][63:32]
//   0xBFF8       mtime[31:0];         0xBFFC      mtime[63:32]
//   Other addresses (incl. i>=N_CORES): reads return 0, writes ignored, still acknowledged.
//  Handshake: valid seen high in cycle N and ready low -> ready=1 in cycle N+1 for exactly one cycle.
//   rdata holds read data only in the ready cycle and is 0 otherwise. A write updates its register at the
//   clock edge that raises ready. Back-to-back requests are acknowledged at most every other cycle.
//   valid dropping before ready is a protocol violation; the bus transaction is undefined.
//  Writes are byte-granular: only bytes whose wstrb bit is set are updated.
//  rt_clk sync: 2-flop synchronizer into clk, then a rising-edge detector. Each detected edge is a tick
//   (one clk pulse, 3 clk after the rt_clk edge). Requires f_clk >= 4*f_rt_clk.
//  Tick: mtime <= mtime+1, 64-bit and unsigned; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
//  A bus write to either mtime half in the same cycle as a tick wins. The written half takes the bus
//   value, the other half keeps its old value, and the increment is dropped.
//  mtip[i] is registered: mtip[i] <= (mtime >= mtimecmp[i]), unsigned 64-bit compare of current values.
//   It is 1 cycle after the operands change and stays level, not pulse.
//  msip[i] = msip reg[i] bit0, combinational from the register, so it changes with the write-ack edge.
//  Reset during a transaction aborts it; ready does not assert for that request.
// CONFIGURATION
//  CLINT_MTIME_LATCH_EN defined: a read of mtime[31:0] also captures mtime[63:32] into a shadow
//   register. The next read of 0xBFFC returns the shadow (tear-free 64-bit read). Writing 0xBFFC
//   updates mtime and the shadow. The shadow resets to 0.
//  Undefined: 0xBFFC reads live mtime[63:32]; software must use the hi-lo-hi read loop.
// TESTING
//  1 After reset, read 0xBFF8, 0xBFFC, 0x4000, 0x4004, 0x0000 -> 0, 0, FFFFFFFF, FFFFFFFF, 0.
//    mtip=0, msip=0. Each ready arrives 1 cycle after valid.
//  2 Write mtimecmp[0]=5, toggle rt_clk 5 times -> mtime=5, and mtip[0] rises 1 clk after mtime hits 5.
//    Write mtimecmp[0]=100 -> mtip[0] falls 1 clk after the write ack.
//  3 N_CORES=4: write 0x0008=1 -> msip=4'b0100. Write 0x0008 with wstrb=4'b0010, wdata=0 -> msip unchanged.
//    Write 0x0010 (core 4) -> ignored, read returns 0, ready still pulses.
//  4 Write mtime to FFFFFFFF_FFFFFFFF with mtimecmp[0]=10, then tick -> mtime=0, mtip[0] drops.
//    Force a tick coincident with a write of 7 to 0xBFF8 -> mtime lo=7, no increment.
//  5 With CLINT_MTIME_LATCH_EN: mtime=0x0_FFFFFFFF, read 0xBFF8, tick, read 0xBFFC -> returns 0
//    (shadow), not 1. Without the macro the same sequence returns 1.
//  6 Assert reset mid-request with mtime=123, msip=1 -> all outputs 0 immediately, no ready.
//    mtime=0 and mtimecmp all-ones after release.

Source files
------------

// File: rtl/clint_mc.sv
// Multi-core core-local interruptor: rt_clk-driven 64-bit mtime, per-core mtimecmp/msip, mtip/msip lines.
// Define CLINT_MTIME_LATCH_EN for a tear-free mtime read (hi half latched by a lo read).
module clint_mc #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int N_CORES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]     rdata,
   output logic                  ready,
   input  logic                  rt_clk,
   output logic [N_CORES-1:0]    mtip,
   output logic [N_CORES-1:0]    msip
);

   logic [2:0]         rt_sync;
   logic               tick;
   logic [63:0]        mtime;
   logic [63:0]        mtimecmp [N_CORES];
   logic [N_CORES-1:0] msip_reg;
   logic [N_CORES-1:0] hit_msip, hit_cmp;
   logic               acc, wr, sel_tlo, sel_thi;
   logic [31:0]        rd;
`ifdef CLINT_MTIME_LATCH_EN
   logic [31:0]        shadow;
`endif

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      for (int b = 0; b < 4; b++)
         if (strb[b]) old[8*b +: 8] = nw[8*b +: 8];
      return old;
   endfunction

   assign tick    = rt_sync[1] & ~rt_sync[2];
   assign acc     = valid & ~ready;
   assign wr      = acc & (|wstrb);
   assign sel_tlo = (address[15:2] == 14'h2FFE);
   assign sel_thi = (address[15:2] == 14'h2FFF);
   assign msip    = msip_reg;

   always_comb begin
      hit_msip = '0;
      hit_cmp  = '0;
      for (int i = 0; i < N_CORES; i++) begin
         hit_msip[i] = (address[15:14] == 2'b00) && (address[13:2] == 12'(i));
         hit_cmp[i]  = (address[15:14] == 2'b01) && (address[13:3] == 11'(i));
      end
   end

   // Unmapped addresses, including cores beyond N_CORES, fall through to zero.
   always_comb begin
      rd = '0;
      for (int i = 0; i < N_CORES; i++) begin
         if (hit_msip[i]) rd = {31'b0, msip_reg[i]};
         if (hit_cmp[i])  rd = address[2] ? mtimecmp[i][63:32] : mtimecmp[i][31:0];
      end
      if (sel_tlo) rd = mtime[31:0];
`ifdef CLINT_MTIME_LATCH_EN
      if (sel_thi) rd = shadow;
`else
      if (sel_thi) rd = mtime[63:32];
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rt_sync <= '0;
         mtime   <= '0;
         ready   <= 1'b0;
         rdata   <= '0;
`ifdef CLINT_MTIME_LATCH_EN
         shadow  <= '0;
`endif
      end else begin
         rt_sync <= {rt_sync[1:0], rt_clk};
         ready   <= acc;
         rdata   <= (acc && !(|wstrb)) ? rd : '0;
         // A bus write to mtime beats a coincident tick; the increment is lost.
         if (wr && sel_tlo)      mtime[31:0]  <= merge(mtime[31:0], wdata, wstrb);
         else if (wr && sel_thi) mtime[63:32] <= merge(mtime[63:32], wdata, wstrb);
         else if (tick)          mtime        <= mtime + 64'd1;
`ifdef CLINT_MTIME_LATCH_EN
         if (acc && !(|wstrb) && sel_tlo) shadow <= mtime[63:32];
         else if (wr && sel_thi)          shadow <= merge(mtime[63:32], wdata, wstrb);
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CORES; i++) mtimecmp[i] <= '1;
         msip_reg <= '0;
         mtip     <= '0;
      end else begin
         for (int i = 0; i < N_CORES; i++) begin
            mtip[i] <= (mtime >= mtimecmp[i]);
            if (wr && hit_msip[i] && wstrb[0]) msip_reg[i] <= wdata[0];
            if (wr && hit_cmp[i]) begin
               if (address[2]) mtimecmp[i][63:32] <= merge(mtimecmp[i][63:32], wdata, wstrb);
               else            mtimecmp[i][31:0]  <= merge(mtimecmp[i][31:0], wdata, wstrb);
            end
         end
      end
   end

endmodule
